// File: rtl/frequency_analyzer_pkg.sv
// Shared types and parameter helpers for the frequency analyzer slice.
// Used by the sync controller and the analyzer readout logic.
package frequency_analyzer_pkg;

  typedef enum logic {
    PHASE_A0 = 1'b0,
    PHASE_A1 = 1'b1
  } phase_t;

  // Window length in system clocks: one reference period.
  function automatic int calc_n(
    input int clock_hz,
    input int freq_hz
  );
    return clock_hz / freq_hz;
  endfunction

  // Counter width for a 0..n-1 range; clamped so a bad n
  // still elaborates far enough to report the real error.
  function automatic int calc_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_counter.sv
// Modulo-N window counter with terminal flags.
// Ports: clock, reset (async, high), enable (low = clear),
//        cnt_zero (cnt==0), cnt_last (cnt==N-1).
module window_counter
  import frequency_analyzer_pkg::*;
#(
  parameter int N = 10,
  parameter int W = calc_w(N)
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic cnt_zero,
  output logic cnt_last
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);
  assign cnt_last = (cnt == LAST);

endmodule

// File: rtl/frequency_analyzer_sync.sv
// Ping-pong start/stop strobes for two frequency analyzers.
// Ports: clock, reset (async, high), enable (run control),
//        start/stop_analyzer_0/1 (registered one-cycle pulses).
module frequency_analyzer_sync
  import frequency_analyzer_pkg::*;
#(
  parameter int FREQUENCY = 2000,
  parameter int CLOCK     = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic start_analyzer_0,
  output logic stop_analyzer_0,
  output logic start_analyzer_1,
  output logic stop_analyzer_1
);

  localparam int N = calc_n(CLOCK, FREQUENCY);
  localparam int W = calc_w(N);

  generate
    if (N < 2) begin : g_bad_n
      $error("frequency_analyzer_sync: CLOCK/FREQUENCY must be >= 2");
    end
  endgenerate

  logic   cnt_zero;
  logic   cnt_last;
  phase_t phase;

  window_counter #(
    .N (N),
    .W (W)
  ) u_window_counter (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cnt_zero (cnt_zero),
    .cnt_last (cnt_last)
  );

  // Dropping enable aborts the current window with no stop pulse
  // and forces the next run to start with analyzer 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase            <= PHASE_A0;
      start_analyzer_0 <= 1'b0;
      stop_analyzer_0  <= 1'b0;
      start_analyzer_1 <= 1'b0;
      stop_analyzer_1  <= 1'b0;
    end else if (!enable) begin
      phase            <= PHASE_A0;
      start_analyzer_0 <= 1'b0;
      stop_analyzer_0  <= 1'b0;
      start_analyzer_1 <= 1'b0;
      stop_analyzer_1  <= 1'b0;
    end else begin
      start_analyzer_0 <= cnt_zero && (phase == PHASE_A0);
      stop_analyzer_0  <= cnt_last && (phase == PHASE_A0);
      start_analyzer_1 <= cnt_zero && (phase == PHASE_A1);
      stop_analyzer_1  <= cnt_last && (phase == PHASE_A1);
      if (cnt_last) begin
        phase <= (phase == PHASE_A0) ? PHASE_A1 : PHASE_A0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_analyzer_sync.sv
// Directed bench for frequency_analyzer_sync at N=10, N=2, N=500.
// Output vectors are packed {stop1, start1, stop0, start0}.
module tb_frequency_analyzer_sync;

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] P0 = 4'b0010;
  localparam logic [3:0] S1 = 4'b0100;
  localparam logic [3:0] P1 = 4'b1000;
  localparam int NV = 26;

  typedef struct {
    logic       en;
    logic [3:0] exp10;
    logic [3:0] exp2;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  logic [3:0] o10, o2, o500;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vec [0:NV];

  always #5 clock = ~clock;

  frequency_analyzer_sync #(.FREQUENCY(1), .CLOCK(10)) dut10 (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .start_analyzer_0 (o10[0]),
    .stop_analyzer_0  (o10[1]),
    .start_analyzer_1 (o10[2]),
    .stop_analyzer_1  (o10[3])
  );

  frequency_analyzer_sync #(.FREQUENCY(5), .CLOCK(10)) dut2 (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .start_analyzer_0 (o2[0]),
    .stop_analyzer_0  (o2[1]),
    .start_analyzer_1 (o2[2]),
    .stop_analyzer_1  (o2[3])
  );

  // 1001/2 truncates to 500
  frequency_analyzer_sync #(.FREQUENCY(2), .CLOCK(1001)) dut500 (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .start_analyzer_0 (o500[0]),
    .stop_analyzer_0  (o500[1]),
    .start_analyzer_1 (o500[2]),
    .stop_analyzer_1  (o500[3])
  );

  task automatic check(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got,
                           input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    check("onehot10", 4'($countones(o10) > 1), 4'd0);
    check("onehot2", 4'($countones(o2) > 1), 4'd0);
    check("onehot500", 4'($countones(o500) > 1), 4'd0);
  end

  // Entered at a negedge with the DUTs idle and cleared.
  task automatic run_table();
    for (int i = 1; i <= NV; i++) begin
      enable = vec[i].en;
      @(posedge clock);
      #1;
      check($sformatf("seq10[%0d]", i), o10, vec[i].exp10);
      check($sformatf("seq2[%0d]", i), o2, vec[i].exp2);
      @(negedge clock);
    end
  endtask

  task automatic restart();
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
  endtask

  int pos [4][$];
  int exp_pos [4][$];

  initial begin
    for (int i = 0; i <= NV; i++) begin
      vec[i].en    = (i <= 24);
      vec[i].exp10 = 4'd0;
      vec[i].exp2  = 4'd0;
    end
    vec[1].exp10  = S0;
    vec[10].exp10 = P0;
    vec[11].exp10 = S1;
    vec[20].exp10 = P1;
    vec[21].exp10 = S0;
    vec[1].exp2 = S0;  vec[2].exp2 = P0;
    vec[3].exp2 = S1;  vec[4].exp2 = P1;
    vec[5].exp2 = S0;  vec[6].exp2 = P0;
    vec[7].exp2 = S1;  vec[8].exp2 = P1;
    vec[9].exp2 = S0;  vec[10].exp2 = P0;
    vec[11].exp2 = S1; vec[12].exp2 = P1;
    vec[13].exp2 = S0; vec[14].exp2 = P0;
    vec[15].exp2 = S1; vec[16].exp2 = P1;
    vec[17].exp2 = S0; vec[18].exp2 = P0;
    vec[19].exp2 = S1; vec[20].exp2 = P1;
    vec[21].exp2 = S0; vec[22].exp2 = P0;
    vec[23].exp2 = S1; vec[24].exp2 = P1;

    exp_pos[0] = '{1, 1001, 2001};
    exp_pos[1] = '{500, 1500};
    exp_pos[2] = '{501, 1501};
    exp_pos[3] = '{1000, 2000};

    #3 reset = 1'b1;
    #1;
    check("rst10", o10, 4'd0);
    check("rst2", o2, 4'd0);
    check("rst500", o500, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      check("idle10", o10, 4'd0);
      check("idle2", o2, 4'd0);
      check("idle500", o500, 4'd0);
    end
    @(negedge clock);

    run_table();

    // Abort at edge 5 of a window: no stop pulse may follow.
    restart();
    enable = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      check("abort10", o10, 4'd0);
      check("abort2", o2, 4'd0);
    end
    @(negedge clock);
    run_table();

    // Async reset between edges while analyzer 1 is active.
    restart();
    enable = 1'b1;
    repeat (13) @(posedge clock);
    #1;
    check("prerst2", o2, S0);
    #2 reset = 1'b1;
    #1;
    check("arst10", o10, 4'd0);
    check("arst2", o2, 4'd0);
    check("arst500", o500, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    run_table();

    // Four windows of N=500 plus the following start.
    restart();
    enable = 1'b1;
    for (int e = 1; e <= 2001; e++) begin
      @(posedge clock);
      #1;
      for (int b = 0; b < 4; b++) begin
        if (o500[b]) pos[b].push_back(e);
      end
    end
    for (int b = 0; b < 4; b++) begin
      check_int($sformatf("n500cnt[%0d]", b), pos[b].size(),
                exp_pos[b].size());
      if (pos[b].size() == exp_pos[b].size()) begin
        for (int k = 0; k < pos[b].size(); k++) begin
          check_int($sformatf("n500pos[%0d][%0d]", b, k),
                    pos[b][k], exp_pos[b][k]);
        end
      end
    end
    if (pos[0].size() >= 2 && pos[1].size() >= 1) begin
      check_int("n500s2s", pos[0][1] - pos[0][0], 1000);
      check_int("n500s2p", pos[1][0] - pos[0][0], 499);
    end else begin
      check_int("n500pulses", pos[0].size(), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frequency_analyzer_sync.md
# frequency_analyzer_sync

Timing controller for a pair of frequency analyzers that measure alternately (ping-pong). It divides the system clock into measurement windows of exactly one reference period, `CLOCK/FREQUENCY` clocks. It issues one-cycle start/stop strobes to analyzer 0 on even windows and to analyzer 1 on odd windows, so one analyzer is always measuring while the other's result is read out. It sits between the clock/enable control and two `frequency_analyzer` instances.

## Interface
- `FREQUENCY`, default 2000: reference frequency in Hz; sets the window length.
- `CLOCK`, default 100000000: system clock frequency in Hz.
- Derived `N = CLOCK/FREQUENCY` (integer division); default 50000. `N >= 2` is required; elaboration error otherwise.
- Derived counter width `W = $clog2(N)`.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `enable`  in  1  run control; low holds the block idle.
- `start_analyzer_0`  out  1  one-cycle pulse: analyzer 0 window begins.
- `stop_analyzer_0`  out  1  one-cycle pulse: analyzer 0 window ends.
- `start_analyzer_1`  out  1  one-cycle pulse: analyzer 1 window begins.
- `stop_analyzer_1`  out  1  one-cycle pulse: analyzer 1 window ends.

## Operation
- State: window counter `cnt` (W bits, range 0..N-1) and `phase` bit (0 = analyzer 0 active, 1 = analyzer 1 active).
- Reset value: `cnt=0`, `phase=0`, all four outputs 0.
- `enable` low, checked on each clock edge: `cnt <= 0`, `phase <= 0`, all outputs <= 0.
- Disabling mid-window aborts the window silently; no stop pulse is issued.
- `enable` high, on each edge:
  - `start_analyzer_x <= (cnt==0) && (phase==x)`
  - `stop_analyzer_x <= (cnt==N-1) && (phase==x)`
  - `cnt <= (cnt==N-1) ? 0 : cnt+1`
  - `phase` toggles when `cnt==N-1`
- All outputs are registered and glitch-free. At most one output is high in any cycle.
- Wrap: `cnt` never exceeds N-1. `phase` alternates indefinitely.
- After reset or re-enable, sequencing always restarts with analyzer 0.

## Timing
- Edge numbering: edge 1 is the first rising edge with `enable=1` after reset or after a low `enable`.
- `start_analyzer_0` is high after edge 1, for one cycle.
- `stop_analyzer_0` is high after edge N.
- `start_analyzer_1` is high after edge N+1.
- `stop_analyzer_1` is high after edge 2N.
- `start_analyzer_0` is high again after edge 2N+1.
- Full cycle period: 2N clocks.
- Window duration: start pulse to stop pulse is N-1 cycles apart, so each window spans N clocks inclusive.
- Stop of one analyzer and start of the other fall on consecutive cycles, never the same cycle.
- Asynchronous reset asserted mid-window: outputs drop to 0 immediately, without waiting for a clock edge.
- Reset dominates `enable`.

## Structure
- Shared package `frequency_analyzer_pkg`, containing:
  - localparam function computing N from CLOCK/FREQUENCY
  - width helper for W
  - `typedef enum logic {PHASE_A0, PHASE_A1}` for the phase bit, also used by the analyzer readout logic
- One natural sub-module, `window_counter`:
  - parameterized modulo-N counter with async reset and synchronous clear on `!enable`
  - outputs `cnt_zero` and `cnt_last` terminal flags
- The top level adds the phase flip-flop and the four output decode registers.

## Test plan
- Reset then idle: `reset=1` → all outputs 0 immediately. Hold `enable=0` for 100 cycles → no pulses.
- Small-N sequence (`FREQUENCY=1`, `CLOCK=10`, N=10). Enable at edge 1 → pulses after:
  - `start_analyzer_0`: edge 1
  - `stop_analyzer_0`: edge 10
  - `start_analyzer_1`: edge 11
  - `stop_analyzer_1`: edge 20
  - `start_analyzer_0`: edge 21
  - Each pulse lasts exactly one cycle.
- Default parameters (N=50000), run 4 windows:
  - start-to-start spacing per analyzer is 100000 cycles
  - start→stop spacing is 49999 cycles
  - at no point are two outputs high together
- Disable mid-window: drop `enable` at N=10 edge 5 → no stop pulse is ever issued. Re-enable → `start_analyzer_0` after the first enabled edge and the full sequence repeats.
- Async reset mid-window: assert `reset` between edges at edge 13 (analyzer 1 active) → outputs 0 with no clock. Release `reset` → sequence restarts with analyzer 0.
- Minimum N=2: pulse order is `start0`, `stop0`, `start1`, `stop1` on consecutive cycles, repeating every 4 cycles.
